// File: rtl/sprite_dma_ram.sv
// ============================================================================
// sprite_dma_ram
// ----------------------------------------------------------------------------
// Sprite object RAM with a CPU byte-lane port and a DMA engine. The DMA engine
// copies the whole object RAM into a display buffer that the sprite renderer
// reads. With DOUBLE_BUF=1 the display buffer has two banks. The copy always
// fills the bank the renderer is not reading, and the banks swap when the copy
// completes, so the renderer only ever sees a complete sprite list.
//
// Parameters
//   AW          word-address width; depth = 2**AW words
//   DW          data width; must be a multiple of 8 (NB = DW/8 byte lanes)
//   DOUBLE_BUF  1 = two display banks swapped at copy end, 0 = one bank
//
// Ports
//   CLK_32M     system clock; all logic uses the rising edge
//   RESET_N     asynchronous active-low reset
//   DIN         CPU write data
//   DOUT        CPU read data; registered, 1-cycle latency
//   DOUT_VALID  MRD & BUFDBEN (combinational)
//   A           CPU word address
//   BYTE_SEL    per-byte-lane write enables
//   BUFDBEN     chip/buffer select
//   MRD         CPU read strobe
//   MWR         CPU write strobe
//   DMA_START   copy request; level input, rising edge detected internally
//   DMA_BUSY    high while a copy is in progress (RUN and DONE states)
//   RD_ADDR     display-side read address
//   RD_DATA     display-side read data; registered, 1-cycle latency
//   BANK        bank the display currently reads (always 0 if DOUBLE_BUF=0)
// ============================================================================
module sprite_dma_ram #(
    parameter int AW         = 9,
    parameter int DW         = 16,
    parameter int DOUBLE_BUF = 1
) (
    input  logic              CLK_32M,
    input  logic              RESET_N,
    input  logic [DW-1:0]     DIN,
    output logic [DW-1:0]     DOUT,
    output logic              DOUT_VALID,
    input  logic [AW-1:0]     A,
    input  logic [DW/8-1:0]   BYTE_SEL,
    input  logic              BUFDBEN,
    input  logic              MRD,
    input  logic              MWR,
    input  logic              DMA_START,
    output logic              DMA_BUSY,
    input  logic [AW-1:0]     RD_ADDR,
    output logic [DW-1:0]     RD_DATA,
    output logic              BANK
);

    localparam int NB    = DW / 8;
    localparam int DEPTH = 1 << AW;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } dma_state_t;

    // ------------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------------
    logic [DW-1:0] obj_mem [DEPTH];

    // ------------------------------------------------------------------------
    // DMA control state
    // ------------------------------------------------------------------------
    dma_state_t    state_q;
    dma_state_t    state_next;

    logic          start_q;        // DMA_START delayed one cycle
    logic          start_armed_q;  // DMA_START has been seen low since reset
    logic          start_edge;
    logic          pending_q;      // one queued request while busy
    logic [AW-1:0] cnt_q;          // word being read from the object RAM
    logic          bank_q;

    // Copy pipeline: the object RAM read happens in cycle k, the display
    // buffer write of that word happens in cycle k+1.
    logic [DW-1:0] dma_rdata_q;
    logic          wr_en_q;
    logic [AW-1:0] wr_addr_q;
    logic          wr_bank_q;

    // Decoded FSM outputs
    logic          busy;
    logic          rd_issue;
    logic          enter_run;
    logic          bank_toggle;

    // A START held high across reset release must not look like a new
    // request, so edges only count once START has been observed low.
    assign start_edge = DMA_START & ~start_q & start_armed_q;

    assign DOUT_VALID = MRD & BUFDBEN;
    assign DMA_BUSY   = busy;
    assign BANK       = bank_q;

    // ------------------------------------------------------------------------
    // CPU port (port A): byte-lane writes, registered read.
    // ------------------------------------------------------------------------
    // NOTE: RAM arrays are never reset; only the control registers around them
    // are, which keeps the arrays mappable onto block RAM.
    always_ff @(posedge CLK_32M) begin
        if (MWR && BUFDBEN) begin
            for (int i = 0; i < NB; i++) begin
                if (BYTE_SEL[i]) begin
                    obj_mem[A][8*i +: 8] <= DIN[8*i +: 8];
                end
            end
        end
    end

    // Same-edge read of a word being written returns the old contents.
    always_ff @(posedge CLK_32M or negedge RESET_N) begin
        if (!RESET_N) begin
            DOUT <= '0;
        end else begin
            DOUT <= obj_mem[A];
        end
    end

    // ------------------------------------------------------------------------
    // DMA read port (port B). Reading obj[k] on the same edge a CPU write lands
    // on obj[k] yields the old word, so a word is captured by the current copy
    // only if the CPU writes it while the counter is still below its index.
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK_32M) begin
        if (rd_issue) begin
            dma_rdata_q <= obj_mem[cnt_q];
        end
    end

    // ------------------------------------------------------------------------
    // DMA FSM: state register
    // ------------------------------------------------------------------------
    // NOTE: sequential blocks use non-blocking assignments so every register
    // samples the values from before the edge, independent of block order.
    always_ff @(posedge CLK_32M or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_next;
        end
    end

    // ------------------------------------------------------------------------
    // DMA FSM: next-state logic
    // ------------------------------------------------------------------------
    // NOTE: every combinational output gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_next = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_edge) begin
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                // The last word has been issued once the counter is all ones.
                if (cnt_q == {AW{1'b1}}) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                // An edge arriving in DONE itself is treated like a pending one.
                if (pending_q || start_edge) begin
                    state_next = S_RUN;
                end else begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // DMA FSM: output decode
    // ------------------------------------------------------------------------
    always_comb begin
        busy        = 1'b0;
        rd_issue    = 1'b0;
        bank_toggle = 1'b0;
        case (state_q)
            S_RUN: begin
                busy     = 1'b1;
                rd_issue = 1'b1;
            end
            S_DONE: begin
                busy        = 1'b1;
                bank_toggle = (DOUBLE_BUF != 0);
            end
            default: ;
        endcase
        enter_run = (state_next == S_RUN) && (state_q != S_RUN);
    end

    // ------------------------------------------------------------------------
    // DMA datapath / bookkeeping registers
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK_32M or negedge RESET_N) begin
        if (!RESET_N) begin
            start_q       <= 1'b0;
            start_armed_q <= 1'b0;
            pending_q     <= 1'b0;
            cnt_q         <= '0;
            bank_q        <= 1'b0;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_bank_q     <= 1'b0;
        end else begin
            start_q <= DMA_START;
            if (!DMA_START) begin
                start_armed_q <= 1'b1;
            end

            // Any number of edges while busy collapse into one request.
            if (enter_run) begin
                pending_q <= 1'b0;
            end else if (start_edge && (state_q != S_IDLE)) begin
                pending_q <= 1'b1;
            end

            if (enter_run) begin
                cnt_q <= '0;
            end else if (rd_issue) begin
                cnt_q <= cnt_q + AW'(1);
            end

            if (bank_toggle) begin
                bank_q <= ~bank_q;
            end

            // The target bank is latched with each word, so the final write
            // committed during DONE still lands in the bank being filled even
            // though BANK flips at the end of that cycle.
            wr_en_q   <= rd_issue;
            wr_addr_q <= cnt_q;
            wr_bank_q <= (DOUBLE_BUF != 0) ? ~bank_q : 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Display buffer: one or two banks, DMA write port + display read port.
    // ------------------------------------------------------------------------
    generate
        if (DOUBLE_BUF != 0) begin : g_double
            logic [DW-1:0] disp_mem [2][DEPTH];

            always_ff @(posedge CLK_32M) begin
                if (wr_en_q) begin
                    disp_mem[wr_bank_q][wr_addr_q] <= dma_rdata_q;
                end
            end

            // BANK flips at the end of DONE, so a read issued during DONE
            // still returns the previous bank.
            always_ff @(posedge CLK_32M or negedge RESET_N) begin
                if (!RESET_N) begin
                    RD_DATA <= '0;
                end else begin
                    RD_DATA <= disp_mem[bank_q][RD_ADDR];
                end
            end
        end else begin : g_single
            logic [DW-1:0] disp_mem [DEPTH];

            always_ff @(posedge CLK_32M) begin
                if (wr_en_q) begin
                    disp_mem[wr_addr_q] <= dma_rdata_q;
                end
            end

            // Written in place: mid-copy reads see new data below the copy
            // pointer and old data above it.
            always_ff @(posedge CLK_32M or negedge RESET_N) begin
                if (!RESET_N) begin
                    RD_DATA <= '0;
                end else begin
                    RD_DATA <= disp_mem[RD_ADDR];
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_sprite_dma_ram.sv
// ============================================================================
// tb_sprite_dma_ram
// ----------------------------------------------------------------------------
// Directed bench for sprite_dma_ram. The main instance uses the default
// parameters (AW=9, DW=16, DOUBLE_BUF=1); a second, small single-bank instance
// (AW=4, DOUBLE_BUF=0) covers in-place copy behaviour. Inputs are driven and
// outputs sampled on the falling clock edge.
// ============================================================================
module tb_sprite_dma_ram;

    logic        clk;
    logic        rst_n;

    // Main instance (double-banked)
    logic [15:0] din;
    logic [15:0] dout;
    logic        dout_valid;
    logic [8:0]  a;
    logic [1:0]  byte_sel;
    logic        bufdben;
    logic        mrd;
    logic        mwr;
    logic        dma_start;
    logic        dma_busy;
    logic [8:0]  rd_addr;
    logic [15:0] rd_data;
    logic        bank;

    // Small single-bank instance
    logic [15:0] s_din;
    logic [15:0] s_dout;
    logic        s_dout_valid;
    logic [3:0]  s_a;
    logic [1:0]  s_byte_sel;
    logic        s_bufdben;
    logic        s_mrd;
    logic        s_mwr;
    logic        s_start;
    logic        s_busy;
    logic [3:0]  s_rd_addr;
    logic [15:0] s_rd_data;
    logic        s_bank;

    int errors;
    int checks;

    sprite_dma_ram #(.AW(9), .DW(16), .DOUBLE_BUF(1)) dut (
        .CLK_32M    (clk),
        .RESET_N    (rst_n),
        .DIN        (din),
        .DOUT       (dout),
        .DOUT_VALID (dout_valid),
        .A          (a),
        .BYTE_SEL   (byte_sel),
        .BUFDBEN    (bufdben),
        .MRD        (mrd),
        .MWR        (mwr),
        .DMA_START  (dma_start),
        .DMA_BUSY   (dma_busy),
        .RD_ADDR    (rd_addr),
        .RD_DATA    (rd_data),
        .BANK       (bank)
    );

    sprite_dma_ram #(.AW(4), .DW(16), .DOUBLE_BUF(0)) dut_sb (
        .CLK_32M    (clk),
        .RESET_N    (rst_n),
        .DIN        (s_din),
        .DOUT       (s_dout),
        .DOUT_VALID (s_dout_valid),
        .A          (s_a),
        .BYTE_SEL   (s_byte_sel),
        .BUFDBEN    (s_bufdben),
        .MRD        (s_mrd),
        .MWR        (s_mwr),
        .DMA_START  (s_start),
        .DMA_BUSY   (s_busy),
        .RD_ADDR    (s_rd_addr),
        .RD_DATA    (s_rd_data),
        .BANK       (s_bank)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // Bus helpers (main instance)
    // ------------------------------------------------------------------------
    task automatic cpu_write(input logic [8:0] addr, input logic [15:0] data,
                             input logic [1:0] sel);
        a        = addr;
        din      = data;
        byte_sel = sel;
        bufdben  = 1'b1;
        mwr      = 1'b1;
        @(negedge clk);
        mwr      = 1'b0;
        bufdben  = 1'b0;
    endtask

    task automatic cpu_read(input logic [8:0] addr, output logic [15:0] data);
        a       = addr;
        mrd     = 1'b1;
        bufdben = 1'b1;
        @(negedge clk);
        data    = dout;
        mrd     = 1'b0;
        bufdben = 1'b0;
    endtask

    // Pulse START and count the cycles DMA_BUSY is high. With watch set, every
    // display read during the copy must return old_val; exit_rd is RD_DATA for
    // the read issued in the DONE cycle.
    task automatic dma_copy(input bit watch, input logic [15:0] old_val,
                            output int cycles, output int bad,
                            output logic [15:0] exit_rd);
        int n;
        bad       = 0;
        dma_start = 1'b1;
        @(negedge clk);
        dma_start = 1'b0;
        n = 0;
        while (dma_busy === 1'b1 && n < 3000) begin
            n++;
            if (watch && rd_data !== old_val) bad++;
            rd_addr = 9'(n * 37);
            @(negedge clk);
        end
        cycles  = n;
        exit_rd = rd_data;
    endtask

    // ------------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (dout !== 16'h0000) begin errors++; $display("FAIL reset_dout: got %h want 0000", dout); end
        checks++; if (rd_data !== 16'h0000) begin errors++; $display("FAIL reset_rd_data: got %h want 0000", rd_data); end
        checks++; if (dma_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", dma_busy); end
        checks++; if (bank !== 1'b0) begin errors++; $display("FAIL reset_bank: got %b want 0", bank); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_cpu_access();
        logic [15:0] r;
        cpu_write(9'd5, 16'h1234, 2'b11);

        a = 9'd5; mrd = 1'b1; bufdben = 1'b1; #1;
        checks++; if (dout_valid !== 1'b1) begin errors++; $display("FAIL dout_valid_on: got %b want 1", dout_valid); end
        bufdben = 1'b0; #1;
        checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL dout_valid_off: got %b want 0", dout_valid); end
        mrd = 1'b0;

        cpu_read(9'd5, r);
        checks++; if (r !== 16'h1234) begin errors++; $display("FAIL read_full: got %h want 1234", r); end

        cpu_write(9'd5, 16'hAA55, 2'b01);
        cpu_read(9'd5, r);
        checks++; if (r !== 16'h1255) begin errors++; $display("FAIL lane0: got %h want 1255", r); end

        cpu_write(9'd5, 16'hBB00, 2'b10);
        cpu_read(9'd5, r);
        checks++; if (r !== 16'hBB55) begin errors++; $display("FAIL lane1: got %h want BB55", r); end

        // Read and write to the same word on the same edge: old data comes back.
        a = 9'd5; din = 16'h7777; byte_sel = 2'b11; mwr = 1'b1; mrd = 1'b1; bufdben = 1'b1;
        @(negedge clk);
        mwr = 1'b0; mrd = 1'b0; bufdben = 1'b0;
        checks++; if (dout !== 16'hBB55) begin errors++; $display("FAIL rdw_old: got %h want BB55", dout); end
        cpu_read(9'd5, r);
        checks++; if (r !== 16'h7777) begin errors++; $display("FAIL rdw_new: got %h want 7777", r); end
    endtask

    // Load 0xFFFF into both display banks, leaving BANK at 0.
    task automatic test_prefill();
        int cyc, bad;
        logic [15:0] ex;
        for (int i = 0; i < 512; i++) cpu_write(9'(i), 16'hFFFF, 2'b11);
        dma_copy(1'b0, 16'h0000, cyc, bad, ex);
        checks++; if (bank !== 1'b1) begin errors++; $display("FAIL prefill_bank1: got %b want 1", bank); end
        dma_copy(1'b0, 16'h0000, cyc, bad, ex);
        checks++; if (bank !== 1'b0) begin errors++; $display("FAIL prefill_bank0: got %b want 0", bank); end
    endtask

    task automatic test_copy_bank();
        int cyc, bad;
        logic [15:0] ex;
        for (int i = 0; i < 512; i++) cpu_write(9'(i), 16'(i), 2'b11);
        dma_copy(1'b1, 16'hFFFF, cyc, bad, ex);
        checks++; if (cyc !== 513) begin errors++; $display("FAIL copy_cycles: got %0d want 513", cyc); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL mid_copy_old_bank: got %0d bad reads want 0", bad); end
        checks++; if (ex !== 16'hFFFF) begin errors++; $display("FAIL done_cycle_read: got %h want FFFF", ex); end
        checks++; if (bank !== 1'b1) begin errors++; $display("FAIL copy_bank_flip: got %b want 1", bank); end
        rd_addr = 9'h1FF;
        @(negedge clk);
        checks++; if (rd_data !== 16'h01FF) begin errors++; $display("FAIL rd_last: got %h want 01FF", rd_data); end
        rd_addr = 9'h000;
        @(negedge clk);
        checks++; if (rd_data !== 16'h0000) begin errors++; $display("FAIL rd_first: got %h want 0000", rd_data); end
    endtask

    task automatic test_back_to_back();
        int cyc, bad, n;
        logic [15:0] ex, rd400, rd10;
        logic bank_mid;
        // Extra copy so this test starts from BANK=0 (both banks hold obj[i]=i).
        dma_copy(1'b0, 16'h0000, cyc, bad, ex);
        checks++; if (bank !== 1'b0) begin errors++; $display("FAIL b2b_pre_bank: got %b want 0", bank); end

        rd400 = '0; rd10 = '0; bank_mid = 1'b0;
        dma_start = 1'b1;
        @(negedge clk);
        dma_start = 1'b0;
        n = 0;
        // At the n-th falling edge the copy counter equals n-1.
        while (dma_busy === 1'b1 && n < 3000) begin
            n++;
            if (n == 101) begin
                a = 9'd400; din = 16'hCAFE; byte_sel = 2'b11; bufdben = 1'b1; mwr = 1'b1;
            end else if (n == 102) begin
                a = 9'd10; din = 16'hBEEF;
            end else begin
                mwr = 1'b0; bufdben = 1'b0;
            end
            if (n == 150) dma_start = 1'b1;
            if (n == 152) dma_start = 1'b0;
            if (n == 155) dma_start = 1'b1;  // second edge collapses into the first
            if (n == 157) dma_start = 1'b0;
            if (n == 700) begin bank_mid = bank; rd_addr = 9'd400; end
            if (n == 701) begin rd400 = rd_data; rd_addr = 9'd10; end
            if (n == 702) rd10 = rd_data;
            @(negedge clk);
        end
        checks++; if (n !== 1026) begin errors++; $display("FAIL b2b_cycles: got %0d want 1026", n); end
        checks++; if (bank_mid !== 1'b1) begin errors++; $display("FAIL b2b_bank_mid: got %b want 1", bank_mid); end
        checks++; if (rd400 !== 16'hCAFE) begin errors++; $display("FAIL b2b_capture_ahead: got %h want CAFE", rd400); end
        checks++; if (rd10 !== 16'h000A) begin errors++; $display("FAIL b2b_behind_old: got %h want 000A", rd10); end
        checks++; if (bank !== 1'b0) begin errors++; $display("FAIL b2b_bank_end: got %b want 0", bank); end
        rd_addr = 9'd10;
        @(negedge clk);
        checks++; if (rd_data !== 16'hBEEF) begin errors++; $display("FAIL b2b_second_copy: got %h want BEEF", rd_data); end
        rd_addr = 9'd400;
        @(negedge clk);
        checks++; if (rd_data !== 16'hCAFE) begin errors++; $display("FAIL b2b_second_400: got %h want CAFE", rd_data); end
    endtask

    task automatic test_single_bank();
        int n;
        logic [15:0] mid_new, mid_old;
        s_bufdben = 1'b1; s_byte_sel = 2'b11;
        for (int i = 0; i < 16; i++) begin
            s_a = 4'(i); s_din = 16'hFFFF; s_mwr = 1'b1;
            @(negedge clk);
        end
        s_mwr = 1'b0;
        s_start = 1'b1; @(negedge clk); s_start = 1'b0;
        n = 0;
        while (s_busy === 1'b1 && n < 200) begin n++; @(negedge clk); end
        checks++; if (n !== 17) begin errors++; $display("FAIL sb_cycles: got %0d want 17", n); end
        checks++; if (s_bank !== 1'b0) begin errors++; $display("FAIL sb_bank: got %b want 0", s_bank); end

        for (int i = 0; i < 16; i++) begin
            s_a = 4'(i); s_din = 16'(16'h0100 + i); s_mwr = 1'b1;
            @(negedge clk);
        end
        s_mwr = 1'b0; s_bufdben = 1'b0;
        mid_new = '0; mid_old = '0;
        s_start = 1'b1; @(negedge clk); s_start = 1'b0;
        n = 0;
        while (s_busy === 1'b1 && n < 200) begin
            n++;
            if (n == 9)  s_rd_addr = 4'd2;
            if (n == 10) begin mid_new = s_rd_data; s_rd_addr = 4'd12; end
            if (n == 11) mid_old = s_rd_data;
            @(negedge clk);
        end
        checks++; if (mid_new !== 16'h0102) begin errors++; $display("FAIL sb_mid_copied: got %h want 0102", mid_new); end
        checks++; if (mid_old !== 16'hFFFF) begin errors++; $display("FAIL sb_mid_pending: got %h want FFFF", mid_old); end
        s_rd_addr = 4'd12;
        @(negedge clk);
        checks++; if (s_rd_data !== 16'h010C) begin errors++; $display("FAIL sb_final: got %h want 010C", s_rd_data); end
    endtask

    task automatic test_reset_abort();
        int cyc, bad, n;
        logic [15:0] ex;
        dma_copy(1'b0, 16'h0000, cyc, bad, ex);
        checks++; if (bank !== 1'b1) begin errors++; $display("FAIL abort_pre_bank: got %b want 1", bank); end

        dma_start = 1'b1;                 // held high through the reset
        @(negedge clk);
        repeat (200) @(negedge clk);      // copy counter is now 200
        rst_n = 1'b0;
        #1;
        checks++; if (dma_busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", dma_busy); end
        checks++; if (bank !== 1'b0) begin errors++; $display("FAIL abort_bank: got %b want 0", bank); end
        checks++; if (dout !== 16'h0000) begin errors++; $display("FAIL abort_dout: got %h want 0000", dout); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        checks++; if (dma_busy !== 1'b0) begin errors++; $display("FAIL held_start_ignored: got %b want 0", dma_busy); end

        dma_start = 1'b0;
        @(negedge clk);
        dma_start = 1'b1;
        @(negedge clk);
        dma_start = 1'b0;
        checks++; if (dma_busy !== 1'b1) begin errors++; $display("FAIL fresh_edge_starts: got %b want 1", dma_busy); end
        n = 0;
        while (dma_busy === 1'b1 && n < 3000) begin n++; @(negedge clk); end
        checks++; if (n !== 513) begin errors++; $display("FAIL post_reset_cycles: got %0d want 513", n); end
        checks++; if (bank !== 1'b1) begin errors++; $display("FAIL post_reset_bank: got %b want 1", bank); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n = 1'b0;
        din = '0; a = '0; byte_sel = '0; bufdben = 1'b0; mrd = 1'b0; mwr = 1'b0;
        dma_start = 1'b0; rd_addr = '0;
        s_din = '0; s_a = '0; s_byte_sel = '0; s_bufdben = 1'b0; s_mrd = 1'b0; s_mwr = 1'b0;
        s_start = 1'b0; s_rd_addr = '0;

        test_reset();
        test_cpu_access();
        test_prefill();
        test_copy_bank();
        test_back_to_back();
        test_single_bank();
        test_reset_abort();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
